dat_vector_packer: RTL and testbench

DAT_VECTOR_PACKER -- requirements
Module: dat_vector_packer

---
 rtl/adder_tree_pkg.sv | 17 +
 rtl/dat_vector_packer.sv | 100 ++++++++++
 tb/tb_dat_vector_packer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants, count-width helper and FSM state type for the vector packer.
package adder_tree_pkg;

    localparam int DEFAULT_NUM_INPUTS = 16;
    localparam int DEFAULT_DWIDTH     = 14;

    // Bits needed to hold a word count in the range 0..n inclusive.
    function automatic int count_width(input int n);
        return $clog2(n + 1);
    endfunction

    typedef enum logic {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/dat_vector_packer.sv
// Packs serial words into a NUM_INPUTS-wide vector and holds it until the consumer takes it.
// Optional running sum of the accepted words is enabled by defining DAT_VECTOR_PACKER_SUM_EN.
module dat_vector_packer
    import adder_tree_pkg::*;
#(
    parameter int NUM_INPUTS = DEFAULT_NUM_INPUTS,
    parameter int DWIDTH     = DEFAULT_DWIDTH
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic [DWIDTH-1:0]                    i_dat,
    input  logic                                 i_valid,
    output logic                                 o_ready,
    input  logic                                 i_flush,
    output logic [NUM_INPUTS*DWIDTH-1:0]         o_dat_vector,
    output logic [count_width(NUM_INPUTS)-1:0]   o_vec_count,
    output logic                                 o_vec_valid,
    input  logic                                 i_vec_ready,
    output logic [DWIDTH-1:0]                    o_sum
);

    localparam int CW = count_width(NUM_INPUTS);

    state_t                       r_state;
    state_t                       w_next_state;
    logic [CW-1:0]                r_idx;
    logic [CW-1:0]                w_idx_inc;
    logic [NUM_INPUTS*DWIDTH-1:0] r_vec;
    logic                         r_ready;
    logic                         r_vec_valid;
    logic                         w_accept;
    logic                         w_handoff;

    assign w_accept  = i_valid & r_ready;
    assign w_handoff = (r_state == HOLD) & i_vec_ready;

    // Flush decision uses the count after this cycle's word, so a word and a flush together close the vector.
    always_comb begin
        w_next_state = r_state;
        w_idx_inc    = r_idx + CW'(w_accept);
        case (r_state)
            FILL: begin
                if (w_accept && (r_idx == CW'(NUM_INPUTS - 1)))
                    w_next_state = HOLD;
                else if (i_flush && (w_idx_inc != '0))
                    w_next_state = HOLD;
            end
            HOLD: begin
                if (i_vec_ready)
                    w_next_state = FILL;
            end
            default: w_next_state = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_idx       <= '0;
            r_vec       <= '0;
            r_ready     <= 1'b0;
            r_vec_valid <= 1'b0;
        end else begin
            r_state     <= w_next_state;
            r_ready     <= (w_next_state == FILL);
            r_vec_valid <= (w_next_state == HOLD);
            if (w_handoff) begin
                r_idx <= '0;
                r_vec <= '0;
            end else if (w_accept) begin
                r_idx <= w_idx_inc;
                for (int k = 0; k < NUM_INPUTS; k++) begin
                    if (r_idx == CW'(k))
                        r_vec[k*DWIDTH +: DWIDTH] <= i_dat;
                end
            end
        end
    end

    assign o_ready      = r_ready;
    assign o_vec_valid  = r_vec_valid;
    assign o_dat_vector = r_vec;
    assign o_vec_count  = r_idx;

`ifdef DAT_VECTOR_PACKER_SUM_EN
    logic [DWIDTH-1:0] r_sum;

    always_ff @(posedge clk) begin
        if (rst || w_handoff)
            r_sum <= '0;
        else if (w_accept)
            r_sum <= r_sum + i_dat;
    end

    assign o_sum = r_sum;
`else
    assign o_sum = '0;
`endif

endmodule

// File: tb/tb_dat_vector_packer.sv
// Self-checking bench for dat_vector_packer: directed table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_dat_vector_packer;
    import adder_tree_pkg::*;

    localparam int N  = 16;
    localparam int DW = 14;
    localparam int CW = count_width(N);
    localparam int VW = N * DW;
`ifdef DAT_VECTOR_PACKER_SUM_EN
    localparam bit SUM_EN = 1'b1;
`else
    localparam bit SUM_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] i_dat = '0;
    logic          i_valid = 1'b0;
    logic          i_flush = 1'b0;
    logic          i_vec_ready = 1'b0;
    logic          o_ready;
    logic [VW-1:0] o_dat_vector;
    logic [CW-1:0] o_vec_count;
    logic          o_vec_valid;
    logic [DW-1:0] o_sum;

    always #5 clk = ~clk;

    dat_vector_packer #(.NUM_INPUTS(N), .DWIDTH(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .i_dat        (i_dat),
        .i_valid      (i_valid),
        .o_ready      (o_ready),
        .i_flush      (i_flush),
        .o_dat_vector (o_dat_vector),
        .o_vec_count  (o_vec_count),
        .o_vec_valid  (o_vec_valid),
        .i_vec_ready  (i_vec_ready),
        .o_sum        (o_sum)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: the words of the vector being built or held, plus handshake flags.
    logic [DW-1:0] mWords[$];
    bit            mHold  = 1'b0;
    bit            mReady = 1'b0;

    typedef struct {
        bit            v;
        logic [DW-1:0] d;
        bit            f;
        bit            vr;
        bit            expReady;
        bit            expValid;
        int            expCount;
        int            expSum;
    } row_t;

    row_t tbl[8];

    function automatic logic [VW-1:0] modelVector();
        logic [VW-1:0] v = '0;
        foreach (mWords[i]) v[i*DW +: DW] = mWords[i];
        return v;
    endfunction

    function automatic logic [DW-1:0] modelSum();
        logic [DW-1:0] s = '0;
        foreach (mWords[i]) s = s + mWords[i];
        return SUM_EN ? s : '0;
    endfunction

    task automatic modelStep(input bit r, input bit v, input logic [DW-1:0] d, input bit f, input bit vr);
        if (r) begin
            mWords.delete();
            mHold  = 1'b0;
            mReady = 1'b0;
        end else if (mHold) begin
            if (vr) begin
                mWords.delete();
                mHold  = 1'b0;
                mReady = 1'b1;
            end
        end else begin
            if (v && mReady) mWords.push_back(d);
            if (mWords.size() == N || (f && mWords.size() > 0)) begin
                mHold  = 1'b1;
                mReady = 1'b0;
            end else begin
                mReady = 1'b1;
            end
        end
    endtask

    task automatic checkVal(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkVal({tag, ".ready"}, VW'(o_ready), VW'(mReady));
        checkVal({tag, ".vec_valid"}, VW'(o_vec_valid), VW'(mHold));
        if (mHold) begin
            checkVal({tag, ".count"}, VW'(o_vec_count), VW'(mWords.size()));
            checkVal({tag, ".vector"}, o_dat_vector, modelVector());
            checkVal({tag, ".sum"}, VW'(o_sum), VW'(modelSum()));
        end
    endtask

    task automatic applyStimulus(input bit r, input bit v, input logic [DW-1:0] d,
                                 input bit f, input bit vr, input string tag);
        @(negedge clk);
        rst         = r;
        i_valid     = v;
        i_dat       = d;
        i_flush     = f;
        i_vec_ready = vr;
        @(posedge clk);
        modelStep(r, v, d, f, vr);
        #1;
        checkOutput(tag);
    endtask

    logic [VW-1:0] vec1to16;
    logic [VW-1:0] snapVec;
    logic [CW-1:0] snapCnt;
    logic [DW-1:0] snapSum;

    initial begin
        tbl[0] = '{1'b1, 14'd5, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1};
        tbl[1] = '{1'b1, 14'd6, 1'b0, 1'b0, 1'b1, 1'b0, -1, -1};
        tbl[2] = '{1'b1, 14'd7, 1'b1, 1'b0, 1'b0, 1'b1,  3, 18};
        tbl[3] = '{1'b0, 14'd0, 1'b1, 1'b0, 1'b0, 1'b1,  3, 18};
        tbl[4] = '{1'b0, 14'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1};
        tbl[5] = '{1'b0, 14'd0, 1'b1, 1'b0, 1'b1, 1'b0, -1, -1};
        tbl[6] = '{1'b1, 14'd9, 1'b1, 1'b0, 1'b0, 1'b1,  1,  9};
        tbl[7] = '{1'b0, 14'd0, 1'b0, 1'b1, 1'b1, 1'b0, -1, -1};

        vec1to16 = '0;
        for (int k = 0; k < N; k++) vec1to16[k*DW +: DW] = DW'(k + 1);

        applyStimulus(1, 0, 0, 0, 0, "reset");
        applyStimulus(1, 1, 14'h0AA, 1, 1, "reset");
        checkVal("reset.count", VW'(o_vec_count), VW'(0));
        checkVal("reset.sum", VW'(o_sum), VW'(0));
        checkVal("reset.vector", o_dat_vector, '0);
        applyStimulus(0, 0, 0, 0, 0, "release");
        checkVal("release.ready_first_cycle", VW'(o_ready), VW'(1));

        foreach (tbl[i]) begin
            applyStimulus(0, tbl[i].v, tbl[i].d, tbl[i].f, tbl[i].vr, $sformatf("tbl%0d", i));
            checkVal($sformatf("tbl%0d.exp_ready", i), VW'(o_ready), VW'(tbl[i].expReady));
            checkVal($sformatf("tbl%0d.exp_valid", i), VW'(o_vec_valid), VW'(tbl[i].expValid));
            if (tbl[i].expCount >= 0)
                checkVal($sformatf("tbl%0d.exp_count", i), VW'(o_vec_count), VW'(tbl[i].expCount));
            if (tbl[i].expSum >= 0)
                checkVal($sformatf("tbl%0d.exp_sum", i), VW'(o_sum), VW'(SUM_EN ? tbl[i].expSum : 0));
        end

        for (int w = 1; w <= N; w++) applyStimulus(0, 1, DW'(w), 0, 1, "seq031");
        checkVal("seq031.slot0", VW'(o_dat_vector[0 +: DW]), VW'(1));
        checkVal("seq031.slot15", VW'(o_dat_vector[15*DW +: DW]), VW'(16));
        checkVal("seq031.count", VW'(o_vec_count), VW'(16));
        checkVal("seq031.sum", VW'(o_sum), VW'(SUM_EN ? 14'h088 : 14'h0));
        checkVal("seq031.vector", o_dat_vector, vec1to16);
        applyStimulus(0, 0, 0, 0, 1, "seq031.handoff");

        for (int w = 0; w < N; w++) applyStimulus(0, 1, DW'(w * 3 + 100), 0, 0, "seq032.fill");
        snapVec = o_dat_vector;
        snapCnt = o_vec_count;
        snapSum = o_sum;
        for (int c = 0; c < 5; c++) begin
            applyStimulus(0, 1, 14'h555, 1, 0, "seq032.hold");
            checkVal("seq032.stable_ready", VW'(o_ready), VW'(0));
            checkVal("seq032.stable_vector", o_dat_vector, snapVec);
            checkVal("seq032.stable_count", VW'(o_vec_count), VW'(snapCnt));
            checkVal("seq032.stable_sum", VW'(o_sum), VW'(snapSum));
        end
        applyStimulus(0, 1, 14'h555, 0, 1, "seq032.handoff");
        checkVal("seq032.handoff_valid", VW'(o_vec_valid), VW'(0));
        applyStimulus(0, 1, 14'h123, 1, 0, "seq032.next");
        checkVal("seq032.next_slot0", VW'(o_dat_vector[0 +: DW]), VW'(14'h123));
        checkVal("seq032.next_count", VW'(o_vec_count), VW'(1));
        applyStimulus(0, 0, 0, 0, 1, "seq032.release");

        for (int w = 0; w < N; w++) applyStimulus(0, 1, 14'h3FFF, 0, 0, "seq034");
        checkVal("seq034.sum_wrap", VW'(o_sum), VW'(SUM_EN ? 14'h3FF0 : 14'h0));
        applyStimulus(0, 0, 0, 0, 1, "seq034.release");

        for (int w = 0; w < 8; w++) applyStimulus(0, 1, DW'(14'h2A0 + w), 0, 0, "seq035.partial");
        applyStimulus(1, 0, 0, 0, 0, "seq035.rst");
        checkVal("seq035.rst_valid", VW'(o_vec_valid), VW'(0));
        applyStimulus(0, 0, 0, 0, 0, "seq035.idle");
        for (int w = 1; w <= N; w++) applyStimulus(0, 1, DW'(w), 0, 0, "seq035.refill");
        checkVal("seq035.vector", o_dat_vector, vec1to16);
        checkVal("seq035.count", VW'(o_vec_count), VW'(16));
        applyStimulus(0, 0, 0, 0, 1, "seq035.handoff");
        applyStimulus(0, 0, 0, 1, 0, "seq035.flush_idx0");
        checkVal("seq035.flush_idx0_valid", VW'(o_vec_valid), VW'(0));
        applyStimulus(0, 0, 0, 1, 0, "seq035.flush_idx0b");

        for (int c = 0; c < 1500; c++) begin
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 9) < 7,
                          DW'($urandom),
                          $urandom_range(0, 9) == 0,
                          $urandom_range(0, 2) == 0,
                          "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
